grf_wport_arbiter: RTL
======================

# grf_wport_arbiter

Shares the single GRF write port between the pipeline W-stage writeback and the long-latency multiply/divide unit (MDU) writeback. Arbitration is fixed-priority toward the pipeline, with an aging counter that guarantees MDU progress. The write port itself is registered. A 32-bit pending-write scoreboard tells the D-stage hazard unit which registers still await an MDU result. The block sits between the W-stage/MDU result buses and the GRF's RegWrite/A3/RFWD inputs.

## Interface
- AGE_MAX, 4: number of consecutive cycles the MDU may be refused before it is force-granted (1..15).
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- P_Valid  in  1  pipeline W-stage write request.
- P_A3  in  5  pipeline destination register.
- P_WD  in  32  pipeline write data.
- P_Ready  out  1  pipeline request accepted this cycle; 0 freezes W-stage.
- M_Valid  in  1  MDU write request.
- M_A3  in  5  MDU destination register.
- M_WD  in  32  MDU write data.
- M_Ready  out  1  MDU request accepted this cycle.
- Iss_Valid  in  1  MDU operation issued (marks destination pending).
- Iss_A3  in  5  destination of the issued MDU operation.
- GRF_RegWrite  out  1  registered write enable to GRF.
- GRF_A3  out  5  registered write address.
- GRF_RFWD  out  32  registered write data.
- Pend_Mask  out  32  bit i = 1 while an MDU write to $i is outstanding.

## Operation
- Grant: grant_m = M_Valid & (~P_Valid | age == AGE_MAX); grant_p = P_Valid & ~grant_m. M_Ready = grant_m, P_Ready = grant_p | ~P_Valid.
- Age counter, 4 bits: increments when M_Valid & ~grant_m, saturating at AGE_MAX. Clears to 0 on grant_m or when M_Valid = 0.
- Write register: on any grant, GRF_A3/GRF_RFWD load the winner's address and data. GRF_RegWrite loads 1 only if the winner's A3 != 0. With no grant, GRF_RegWrite loads 0 and address/data hold.
- Writes to $0 are accepted (Ready = 1) and discarded. Their pending bits never set.
- Scoreboard set: Iss_Valid & Iss_A3 != 0 sets Pend_Mask[Iss_A3].
- Scoreboard clear: clears Pend_Mask[GRF_A3] when GRF_RegWrite = 1 and that write was an MDU write (tracked by a registered src_m flag).
- Same-register set and clear in one cycle: set wins, because a new MDU operation is outstanding.
- The arbiter does not reorder by register. Writes reach the GRF strictly in grant order.

## Timing
- Ready outputs are combinational from Valid and age. Valid must not depend combinationally on Ready.
- A request granted in cycle t drives GRF_* during cycle t+1. The GRF commits it at the t+1/t+2 edge.
- The pending bit for an MDU write clears at the same edge the GRF commits it (end of t+1), so the hazard unit never sees a cleared bit before the data is readable.
- Forced MDU grant: after AGE_MAX consecutive refused cycles, the next cycle grants MDU and drives P_Ready = 0 for exactly one cycle.
- Reset asserted, at any time: GRF_RegWrite = 0, GRF_A3 = 0, GRF_RFWD = 0, Pend_Mask = 0, age = 0, src_m = 0, all immediately and asynchronously. An in-flight registered write is dropped. Ready outputs follow the grant equations once Reset deasserts.

## Structure
- Shared package grf_arb_pkg holds:
  - REG_AW = 5, DATA_W = 32, NUM_REGS = 32;
  - AGE_W = 4 and the AGE_MAX default;
  - a struct {valid, a3, wd} for write requests.
- One sub-module, grf_pend_scoreboard, holds the 32-bit mask with its set/clear/priority logic. The arbiter, age counter and write register stay in the top.

## Test plan
- Reset release, then P_Valid = 1, P_A3 = 5, P_WD = 0x1234 in cycle 0 -> P_Ready = 1 in cycle 0; cycle 1 shows GRF_RegWrite = 1, GRF_A3 = 5, GRF_RFWD = 0x1234.
- Iss_Valid with Iss_A3 = 8 -> Pend_Mask = 0x100. Then M_Valid, M_A3 = 8, M_WD = 0xDEAD with P_Valid = 0 -> M_Ready = 1; Pend_Mask returns to 0 exactly one edge after the GRF_RegWrite cycle.
- P_Valid and M_Valid held high continuously, AGE_MAX = 4 -> P wins 4 cycles, cycle 5 has M_Ready = 1 and P_Ready = 0, age returns to 0, P wins again.
- P_A3 = 0 with P_WD = 0xFFFF_FFFF -> P_Ready = 1; next cycle GRF_RegWrite = 0. Iss_A3 = 0 -> Pend_Mask unchanged.
- Iss_Valid with Iss_A3 = 3 in the same cycle the MDU write to $3 commits -> Pend_Mask[3] stays 1.
- Reset pulsed low mid-cycle while GRF_RegWrite = 1 and Pend_Mask = 0x0000_0F00 -> all outputs 0 immediately, before the next Clk edge.

Source files
------------

// File: rtl/grf_arb_pkg.sv
`default_nettype none
// ============================================================================
// grf_arb_pkg : shared widths, aging default and write-request struct for the
//               GRF write-port arbiter.   Rev 1.0
// ============================================================================
package grf_arb_pkg;

   localparam int REG_AW      = 5;
   localparam int DATA_W      = 32;
   localparam int NUM_REGS    = 32;
   localparam int AGE_W       = 4;
   localparam int AGE_MAX_DEF = 4;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] a3;
      logic [DATA_W-1:0] wd;
   } wreq_t;

endpackage
`default_nettype wire

// File: rtl/grf_pend_scoreboard.sv
`default_nettype none
// ============================================================================
// grf_pend_scoreboard : one bit per GRF register, set on MDU issue, cleared on
//                       MDU commit; a same-cycle set beats the clear. Rev 1.0
// ============================================================================
module grf_pend_scoreboard
   import grf_arb_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                set_valid,
   input  logic [REG_AW-1:0]   set_a3,
   input  logic                clr_valid,
   input  logic [REG_AW-1:0]   clr_a3,
   output logic [NUM_REGS-1:0] pend_mask
);

   logic [NUM_REGS-1:0] r_mask;
   logic [NUM_REGS-1:0] w_set;
   logic [NUM_REGS-1:0] w_clr;

   // $0 is never tracked: it cannot hold a result the hazard unit waits on.
   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (set_valid && (set_a3 != '0)) w_set[set_a3] = 1'b1;
      if (clr_valid)                   w_clr[clr_a3] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_mask <= '0;
      else        r_mask <= (r_mask & ~w_clr) | w_set;
   end

   assign pend_mask = r_mask;

endmodule
`default_nettype wire

// File: rtl/grf_wport_arbiter.sv
`default_nettype none
// ============================================================================
// grf_wport_arbiter : pipeline-priority arbiter with MDU aging for the single
//                     registered GRF write port, plus pending-write mask. Rev 1.0
// ============================================================================
module grf_wport_arbiter
   import grf_arb_pkg::*;
#(
   parameter int AGE_MAX = AGE_MAX_DEF
)(
   input  logic                Clk,
   input  logic                Reset,
   input  logic                P_Valid,
   input  logic [REG_AW-1:0]   P_A3,
   input  logic [DATA_W-1:0]   P_WD,
   output logic                P_Ready,
   input  logic                M_Valid,
   input  logic [REG_AW-1:0]   M_A3,
   input  logic [DATA_W-1:0]   M_WD,
   output logic                M_Ready,
   input  logic                Iss_Valid,
   input  logic [REG_AW-1:0]   Iss_A3,
   output logic                GRF_RegWrite,
   output logic [REG_AW-1:0]   GRF_A3,
   output logic [DATA_W-1:0]   GRF_RFWD,
   output logic [NUM_REGS-1:0] Pend_Mask
);

   localparam logic [AGE_W-1:0] c_age_max = AGE_W'(AGE_MAX);

   logic              r_we;
   logic              r_src_m;
   logic [REG_AW-1:0] r_a3;
   logic [DATA_W-1:0] r_wd;
   logic [AGE_W-1:0]  r_age;

   wreq_t w_preq;
   wreq_t w_mreq;
   wreq_t w_win;
   logic  w_grant_m;
   logic  w_grant_p;

   assign w_preq = '{valid: P_Valid, a3: P_A3, wd: P_WD};
   assign w_mreq = '{valid: M_Valid, a3: M_A3, wd: M_WD};

   assign w_grant_m = M_Valid & (~P_Valid | (r_age == c_age_max));
   assign w_grant_p = P_Valid & ~w_grant_m;
   // The winner's valid bit is exactly "some grant happened this cycle".
   assign w_win     = w_grant_m ? w_mreq : w_preq;

   assign M_Ready = w_grant_m;
   assign P_Ready = w_grant_p | ~P_Valid;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_age <= '0;
      end else if (!M_Valid || w_grant_m) begin
         r_age <= '0;
      end else if (r_age != c_age_max) begin
         r_age <= r_age + 4'd1;
      end
   end

   // Address/data hold when idle so GRF_A3 stays stable for the scoreboard.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_we    <= 1'b0;
         r_src_m <= 1'b0;
         r_a3    <= '0;
         r_wd    <= '0;
      end else if (w_win.valid) begin
         r_we    <= (w_win.a3 != '0);
         r_src_m <= w_grant_m;
         r_a3    <= w_win.a3;
         r_wd    <= w_win.wd;
      end else begin
         r_we    <= 1'b0;
         r_src_m <= 1'b0;
      end
   end

   assign GRF_RegWrite = r_we;
   assign GRF_A3       = r_a3;
   assign GRF_RFWD     = r_wd;

   grf_pend_scoreboard u_pend (
      .clk       (Clk),
      .rst_n     (Reset),
      .set_valid (Iss_Valid),
      .set_a3    (Iss_A3),
      .clr_valid (r_we & r_src_m),
      .clr_a3    (r_a3),
      .pend_mask (Pend_Mask)
   );

endmodule
`default_nettype wire
